// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multi-cycle, non-pipelined MIPS32 (little-endian) integer core
// with a single Avalon-MM style master port shared by fetch and data access.
// Boots from RESET_VECTOR and halts once it tries to fetch from address 0.
//
// Optional feature macro: HILO_MULT_EN
//   defined     -> HI/LO registers plus MULT, MULTU, MFHI, MFLO, MTHI, MTLO
//   not defined -> those six opcodes execute as NOPs, no HI/LO storage
//
// Bus handshake: read or write is raised together with address/writedata,
// all taken straight from registers, and held unchanged while waitrequest=1.
// The access completes on the rising edge where waitrequest=0; readdata is
// sampled on that same edge. read and write are never high at the same time.
//
// The FSM state is visible as state_q (type state_t) for bound checkers.

module mips_cpu_bus #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        active,
   output logic [31:0] register_v0,
   output logic [31:0] address,
   output logic        write,
   output logic        read,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;
`ifdef HILO_MULT_EN
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
`endif

   // Architectural and bus state
   state_t      state_q;
   logic [31:0] pc_q;          // address of the instruction being fetched/executed
   logic [31:0] npc_q;         // address of the next instruction (delay slot aware)
   logic [31:0] instr_q;
   logic        active_q;
   logic        read_q;
   logic        write_q;
   logic [31:0] address_q;
   logic [31:0] writedata_q;
   logic [31:0] gpr_q [32];

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] jidx;

   // Operands and derived addresses
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] simm;
   logic [31:0] zimm;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] mem_addr;
   logic        is_lw;
   logic        is_sw;

   // Execute results
   logic [31:0] pc_d;
   logic [31:0] npc_d;
   logic        exec_we;
   logic [4:0]  exec_rd;
   logic [31:0] exec_data;

   // Register file write port
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

`ifdef HILO_MULT_EN
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] hi_d;
   logic [31:0] lo_d;
   logic        hilo_we;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
`endif

   assign opcode = instr_q[31:26];
   assign rs     = instr_q[25:21];
   assign rt     = instr_q[20:16];
   assign rd     = instr_q[15:11];
   assign shamt  = instr_q[10:6];
   assign funct  = instr_q[5:0];
   assign imm    = instr_q[15:0];
   assign jidx   = instr_q[25:0];

   assign rs_val    = gpr_q[rs];
   assign rt_val    = gpr_q[rt];
   assign simm      = {{16{imm[15]}}, imm};
   assign zimm      = {16'h0000, imm};
   assign pc_plus4  = pc_q + 32'd4;
   assign link_addr = pc_plus4 + 32'd4;
   // npc_q is the delay-slot PC while a branch executes
   assign br_target = npc_q + {simm[29:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], jidx, 2'b00};
   // Unaligned data accesses are silently forced onto a word boundary
   assign mem_addr  = (rs_val + simm) & 32'hFFFF_FFFC;
   assign is_lw     = (opcode == OP_LW);
   assign is_sw     = (opcode == OP_SW);
   // The delay slot (or fall-through) always becomes the next instruction
   assign pc_d      = npc_q;

`ifdef HILO_MULT_EN
   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'h0, rs_val} * {32'h0, rt_val};
`endif

   // Decode, ALU and branch resolution for the latched instruction
   always_comb begin
      npc_d     = npc_q + 32'd4;
      exec_we   = 1'b0;
      exec_rd   = rt;
      exec_data = 32'd0;
`ifdef HILO_MULT_EN
      hilo_we   = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
`endif
      case (opcode)
         OP_SPECIAL: begin
            exec_rd = rd;
            case (funct)
               F_SLL:  begin exec_we = 1'b1; exec_data = rt_val << shamt; end
               F_SRL:  begin exec_we = 1'b1; exec_data = rt_val >> shamt; end
               F_SRA:  begin exec_we = 1'b1; exec_data = $unsigned($signed(rt_val) >>> shamt); end
               F_SLLV: begin exec_we = 1'b1; exec_data = rt_val << rs_val[4:0]; end
               F_SRLV: begin exec_we = 1'b1; exec_data = rt_val >> rs_val[4:0]; end
               F_SRAV: begin exec_we = 1'b1; exec_data = $unsigned($signed(rt_val) >>> rs_val[4:0]); end
               F_JR:   npc_d = rs_val;
               F_JALR: begin npc_d = rs_val; exec_we = 1'b1; exec_data = link_addr; end
               F_ADDU: begin exec_we = 1'b1; exec_data = rs_val + rt_val; end
               F_SUBU: begin exec_we = 1'b1; exec_data = rs_val - rt_val; end
               F_AND:  begin exec_we = 1'b1; exec_data = rs_val & rt_val; end
               F_OR:   begin exec_we = 1'b1; exec_data = rs_val | rt_val; end
               F_XOR:  begin exec_we = 1'b1; exec_data = rs_val ^ rt_val; end
               F_NOR:  begin exec_we = 1'b1; exec_data = ~(rs_val | rt_val); end
               F_SLT:  begin exec_we = 1'b1; exec_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
               F_SLTU: begin exec_we = 1'b1; exec_data = {31'd0, rs_val < rt_val}; end
`ifdef HILO_MULT_EN
               F_MFHI:  begin exec_we = 1'b1; exec_data = hi_q; end
               F_MFLO:  begin exec_we = 1'b1; exec_data = lo_q; end
               F_MTHI:  begin hilo_we = 1'b1; hi_d = rs_val; end
               F_MTLO:  begin hilo_we = 1'b1; lo_d = rs_val; end
               F_MULT:  begin hilo_we = 1'b1; hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
               F_MULTU: begin hilo_we = 1'b1; hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
`endif
               default: ;
            endcase
         end
         OP_REGIMM: begin
            if ((rt == 5'd0) && rs_val[31]) npc_d = br_target;       // BLTZ
            if ((rt == 5'd1) && !rs_val[31]) npc_d = br_target;      // BGEZ
         end
         OP_J:    npc_d = j_target;
         OP_JAL:  begin npc_d = j_target; exec_we = 1'b1; exec_rd = 5'd31; exec_data = link_addr; end
         OP_BEQ:  if (rs_val == rt_val) npc_d = br_target;
         OP_BNE:  if (rs_val != rt_val) npc_d = br_target;
         OP_BLEZ: if (rs_val[31] || (rs_val == 32'd0)) npc_d = br_target;
         OP_BGTZ: if (!rs_val[31] && (rs_val != 32'd0)) npc_d = br_target;
         OP_ADDIU: begin exec_we = 1'b1; exec_data = rs_val + simm; end
         OP_SLTI:  begin exec_we = 1'b1; exec_data = {31'd0, $signed(rs_val) < $signed(simm)}; end
         OP_SLTIU: begin exec_we = 1'b1; exec_data = {31'd0, rs_val < simm}; end
         OP_ANDI:  begin exec_we = 1'b1; exec_data = rs_val & zimm; end
         OP_ORI:   begin exec_we = 1'b1; exec_data = rs_val | zimm; end
         OP_XORI:  begin exec_we = 1'b1; exec_data = rs_val ^ zimm; end
         OP_LUI:   begin exec_we = 1'b1; exec_data = {imm, 16'h0000}; end
         default: ;
      endcase
   end

   // Select the register file write: EXEC results, or load data on LW accept
   always_comb begin
      wb_en   = 1'b0;
      wb_addr = 5'd0;
      wb_data = 32'd0;
      if ((state_q == S_EXEC) && exec_we) begin
         wb_en   = 1'b1;
         wb_addr = exec_rd;
         wb_data = exec_data;
      end else if ((state_q == S_MEM) && is_lw && !waitrequest) begin
         wb_en   = 1'b1;
         wb_addr = rt;
         wb_data = readdata;
      end
   end

   // Main control FSM with registered bus outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_VECTOR;
         npc_q       <= RESET_VECTOR + 32'd4;
         instr_q     <= 32'd0;
         active_q    <= 1'b1;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         address_q   <= 32'd0;
         writedata_q <= 32'd0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (!read_q) begin
                  // No fetch issued yet: either start one or stop at PC 0
                  if (pc_q == 32'd0) begin
                     state_q  <= S_HALT;
                     active_q <= 1'b0;
                  end else begin
                     read_q    <= 1'b1;
                     address_q <= pc_q;
                  end
               end else if (!waitrequest) begin
                  instr_q <= readdata;
                  read_q  <= 1'b0;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               pc_q  <= pc_d;
               npc_q <= npc_d;
               if (is_lw) begin
                  read_q    <= 1'b1;
                  address_q <= mem_addr;
                  state_q   <= S_MEM;
               end else if (is_sw) begin
                  write_q     <= 1'b1;
                  address_q   <= mem_addr;
                  writedata_q <= rt_val;
                  state_q     <= S_MEM;
               end else begin
                  // Issue the next fetch straight away to keep CPI at 2
                  state_q <= S_FETCH;
                  if (pc_d != 32'd0) begin
                     read_q    <= 1'b1;
                     address_q <= pc_d;
                  end
               end
            end
            S_MEM: begin
               if (!waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= S_FETCH;
                  if (pc_q != 32'd0) begin
                     read_q    <= 1'b1;
                     address_q <= pc_q;
                  end
               end
            end
            S_HALT: begin
               active_q <= 1'b0;
               read_q   <= 1'b0;
               write_q  <= 1'b0;
            end
            default: state_q <= S_HALT;
         endcase
      end
   end

   // General purpose registers; $0 is never written so it always reads 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'd0;
      end else if (wb_en && (wb_addr != 5'd0)) begin
         gpr_q[wb_addr] <= wb_data;
      end
   end

`ifdef HILO_MULT_EN
   // HI/LO multiply result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if ((state_q == S_EXEC) && hilo_we) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
`endif

   assign active      = active_q;
   assign register_v0 = gpr_q[2];
   assign address     = address_q;
   assign read        = read_q;
   assign write       = write_q;
   assign writedata   = writedata_q;
   assign byteenable  = 4'b1111;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb_mips_cpu_bus: directed programs for mips_cpu_bus against a word memory
// model with optional random waitrequest stalls.
module tb_mips_cpu_bus;

  localparam int BUDGET = 3000;
  localparam int OP_ADDIU = 9;
  localparam int OP_ORI = 13;
  localparam int OP_LUI = 15;
  localparam int OP_LW = 35;
  localparam int OP_SW = 43;
  localparam int OP_BEQ = 4;
  localparam int OP_BNE = 5;
  localparam int OP_JAL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        active;
  logic [31:0] register_v0;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  mips_cpu_bus dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem    [0:1023];   // program image, written only by the driver
  logic [31:0] st_dat [0:1023];   // words stored by the DUT
  logic        st_vld [0:1023];
  int          stall_cnt;
  int          wait_max;

  assign readdata    = st_vld[address[11:2]] ? st_dat[address[11:2]] : mem[address[11:2]];
  assign waitrequest = (stall_cnt != 0);

  always @(posedge clk) begin
    if (reset) begin
      stall_cnt <= (wait_max > 0) ? $urandom_range(wait_max, 0) : 0;
      for (int i = 0; i < 1024; i++) st_vld[i] <= 1'b0;
    end else if (read || write) begin
      if (stall_cnt == 0) begin
        if (write) begin
          st_vld[address[11:2]] <= 1'b1;
          st_dat[address[11:2]] <= writedata;
        end
        stall_cnt <= (wait_max > 0) ? $urandom_range(wait_max, 0) : 0;
      end else begin
        stall_cnt <= stall_cnt - 1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic        rw_both;
  logic        addr_bad;
  int          ds_cnt;
  logic [31:0] ds_addr;
  logic [3:0]  sw_be;
  logic [31:0] sw_addr;
  logic [31:0] sw_data;

  always @(negedge clk) begin
    if (reset) begin
      rw_both  = 1'b0;
      addr_bad = 1'b0;
      ds_cnt   = 0;
      sw_be    = 4'h0;
      sw_addr  = 32'h0;
      sw_data  = 32'h0;
    end else begin
      if (read && write) rw_both = 1'b1;
      if ((read || write) && (address[1:0] != 2'b00)) addr_bad = 1'b1;
      if (read && !waitrequest && (address == ds_addr)) ds_cnt++;
      if (write && !waitrequest) begin
        sw_be   = byteenable;
        sw_addr = address;
        sw_data = writedata;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] o, s, t, m;
    o = op; s = rs; t = rt; m = imm;
    return {o[5:0], s[4:0], t[4:0], m[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sa, input int fn);
    logic [31:0] s, t, d, a, f;
    s = rs; t = rt; d = rd; a = sa; f = fn;
    return {6'd0, s[4:0], t[4:0], d[4:0], a[4:0], f[5:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int idx);
    logic [31:0] o, x;
    o = op; x = idx;
    return {o[5:0], x[25:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic load_halt_prog();
    clear_mem();
    mem[0] = enc_i(OP_ADDIU, 0, 2, -1);
    mem[1] = enc_r(0, 0, 0, 0, 8);            // JR $0
    mem[2] = enc_r(0, 0, 0, 0, 0);            // SLL $0,$0,0
  endtask

  task automatic load_branch_prog(input bit use_bne);
    clear_mem();
    mem[0]  = enc_i(OP_LUI, 0, 3, 'hBFC0);
    mem[1]  = enc_i(OP_LW, 3, 9, 'h28);
    mem[2]  = enc_i(OP_LW, 3, 10, 'h28);
    mem[3]  = enc_i(use_bne ? OP_BNE : OP_BEQ, 10, 9, 9);   // target 0x34
    mem[4]  = enc_i(OP_ADDIU, 4, 4, 1);                    // delay slot
    mem[5]  = enc_i(OP_LW, 3, 2, 'h30);                    // fall-through
    mem[6]  = enc_r(0, 0, 0, 0, 8);
    mem[7]  = 32'h0;
    mem[10] = 32'hBE4D927F;
    mem[12] = 32'hCAFEF00D;
    mem[13] = enc_i(OP_LW, 3, 2, 'h28);                    // taken target
    mem[14] = enc_r(0, 0, 0, 0, 8);
    mem[15] = 32'h0;
  endtask

  task automatic load_alu_prog();
    clear_mem();
    mem[0]  = enc_i(OP_ADDIU, 0, 4, 'h00F0);
    mem[1]  = enc_i(OP_ADDIU, 0, 5, -16);
    mem[2]  = enc_r(4, 5, 6, 0, 'h24);        // AND  -> 0x000000F0
    mem[3]  = enc_r(0, 5, 7, 4, 'h03);        // SRA  -> 0xFFFFFFFF
    mem[4]  = enc_r(5, 4, 8, 0, 'h2A);        // SLT  -> 1
    mem[5]  = enc_r(5, 4, 9, 0, 'h2B);        // SLTU -> 0
    mem[6]  = 32'hFC000000;                   // unimplemented opcode
    mem[7]  = enc_r(6, 8, 2, 0, 'h21);        // ADDU -> 0xF1
    mem[8]  = enc_r(2, 7, 2, 0, 'h26);        // XOR  -> 0xFFFFFF0E
    mem[9]  = enc_r(9, 2, 2, 0, 'h21);        // ADDU +0
    mem[10] = enc_r(0, 0, 0, 0, 8);
    mem[11] = 32'h0;
  endtask

  task automatic load_jal_prog();
    clear_mem();
    mem[0] = enc_j(OP_JAL, 'h3F00004);        // -> 0xBFC00010
    mem[1] = enc_i(OP_ADDIU, 0, 4, 7);        // delay slot
    mem[2] = enc_i(OP_ADDIU, 0, 2, 'h5555);   // skipped
    mem[3] = enc_r(0, 0, 0, 0, 8);            // skipped
    mem[4] = enc_r(31, 4, 2, 0, 'h21);        // $2 = 0xBFC00008 + 7
    mem[5] = enc_r(0, 0, 0, 0, 8);
    mem[6] = 32'h0;
  endtask

  task automatic load_store_prog();
    clear_mem();
    mem[0] = enc_i(OP_LUI, 0, 3, 'hBFC0);
    mem[1] = enc_i(OP_LUI, 0, 5, 'h1234);
    mem[2] = enc_i(OP_ORI, 5, 5, 'h5678);
    mem[3] = enc_i(OP_SW, 3, 5, 'h40);
    mem[4] = enc_i(OP_LW, 3, 2, 'h40);
    mem[5] = enc_r(0, 0, 0, 0, 8);
    mem[6] = 32'h0;
  endtask

  task automatic load_unaligned_prog();
    clear_mem();
    mem[0]  = enc_i(OP_LUI, 0, 3, 'hBFC0);
    mem[1]  = enc_i(OP_LW, 3, 2, 'h2B);       // forced to 0xBFC00028
    mem[2]  = enc_r(0, 0, 0, 0, 8);
    mem[3]  = 32'h0;
    mem[10] = 32'hBE4D927F;
  endtask

  task automatic run_prog(input int max_wait);
    int cyc;
    wait_max = max_wait;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (active && (cyc < BUDGET)) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic end_prog(input string name);
    check_eq({name, "_halted"}, {31'd0, active}, 32'd0);
    check_eq({name, "_v0"}, register_v0, exp_q.pop_front());
    check_eq({name, "_rw_excl"}, {31'd0, rw_both}, 32'd0);
    check_eq({name, "_aligned"}, {31'd0, addr_bad}, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    reset    = 1'b1;
    wait_max = 0;
    ds_addr  = 32'hBFC00010;
    load_halt_prog();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_active", {31'd0, active}, 32'd1);
    check_eq("rst_read", {31'd0, read}, 32'd0);
    check_eq("rst_write", {31'd0, write}, 32'd0);
    check_eq("rst_address", address, 32'd0);
    check_eq("rst_writedata", writedata, 32'd0);
    check_eq("rst_byteenable", {28'd0, byteenable}, 32'hF);

    // First fetch after release
    reset = 1'b0;
    cyc = 0;
    while (!read && (cyc < 10)) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("first_read", {31'd0, read}, 32'd1);
    check_eq("first_addr", address, 32'hBFC00000);
    check_eq("first_active", {31'd0, active}, 32'd1);

    // ADDIU / JR $0 / SLL halt
    load_halt_prog();
    exp_q.push_back(32'hFFFFFFFF);
    run_prog(0);
    end_prog("halt");
    repeat (8) @(negedge clk);
    check_eq("halt_persist_active", {31'd0, active}, 32'd0);
    check_eq("halt_persist_read", {31'd0, read}, 32'd0);

    // Branch taken / not taken, zero wait
    load_branch_prog(1'b0);
    exp_q.push_back(32'hBE4D927F);
    run_prog(0);
    end_prog("beq");
    check_eq("beq_delay_once", ds_cnt, 32'd1);

    load_branch_prog(1'b1);
    exp_q.push_back(32'hCAFEF00D);
    run_prog(0);
    end_prog("bne");
    check_eq("bne_delay_once", ds_cnt, 32'd1);

    // ALU, jump-and-link, unaligned load
    load_alu_prog();
    exp_q.push_back(32'hFFFFFF0E);
    run_prog(0);
    end_prog("alu");

    load_jal_prog();
    exp_q.push_back(32'hBFC0000F);
    run_prog(0);
    end_prog("jal");

    load_unaligned_prog();
    exp_q.push_back(32'hBE4D927F);
    run_prog(0);
    end_prog("unaligned");

    // Store then load back
    load_store_prog();
    exp_q.push_back(32'h12345678);
    run_prog(0);
    end_prog("store");
    check_eq("sw_addr", sw_addr, 32'hBFC00040);
    check_eq("sw_data", sw_data, 32'h12345678);
    check_eq("sw_be", {28'd0, sw_be}, 32'hF);

    // Same programs with random 0..5 cycle stalls
    load_branch_prog(1'b0);
    exp_q.push_back(32'hBE4D927F);
    run_prog(5);
    end_prog("beq_wait");
    check_eq("beq_wait_delay_once", ds_cnt, 32'd1);

    load_branch_prog(1'b1);
    exp_q.push_back(32'hCAFEF00D);
    run_prog(5);
    end_prog("bne_wait");

    load_store_prog();
    exp_q.push_back(32'h12345678);
    run_prog(5);
    end_prog("store_wait");
    check_eq("sw_wait_data", sw_data, 32'h12345678);

    // Reset asserted in the middle of a stalled access aborts it at once
    load_branch_prog(1'b0);
    wait_max = 5;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    while (!read && (cyc < 20)) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_read_seen", {31'd0, read}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_read", {31'd0, read}, 32'd0);
    check_eq("mid_rst_address", address, 32'd0);
    check_eq("mid_rst_active", {31'd0, active}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
